// File: rtl/seg_display_pkg.sv
// Shared types, segment constants and the BCD-to-segment decoder for the
// seven-segment display controller (segments active-low, bit 6 = g .. bit 0 = a).
package seg_display_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  function automatic logic [6:0] digit_to_seg(input bcd_digit_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one magnitude bit per clock, WIDTH clocks
// per conversion, result and overflow published together on the final iteration.
module bin2bcd_seq
  import seg_display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [WIDTH-1:0]      i_mag,
  input  logic                  i_neg,
  output logic                  o_busy,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_overflow,
  output logic                  o_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    r_mag;
  logic [4*DIGITS-1:0] r_work;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;

  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_shifted;
  logic                w_carry;
  logic                w_last;
  logic                w_start;
  logic                w_top_nz;

  // Add-3 correction on every digit, then shift the next magnitude bit in.
  always_comb begin
    w_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      w_adj[4*d +: 4] = (r_work[4*d +: 4] >= 4'd5) ? (r_work[4*d +: 4] + 4'd3)
                                                    : r_work[4*d +: 4];
    end
    w_shifted = {w_adj[4*DIGITS-2:0], r_mag[WIDTH-1]};
    w_carry   = w_adj[4*DIGITS-1];
    w_top_nz  = |w_shifted[4*DIGITS-1 -: 4];
    w_last    = o_busy && (r_cnt == CNT_W'(WIDTH - 1));
    w_start   = i_load && (!o_busy || w_last);
  end

  assign o_done = w_last;

  // Conversion state and published result; a load on the final iteration starts the next run.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mag      <= '0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      o_busy     <= 1'b0;
      o_bcd      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (w_start) begin
        r_mag  <= i_mag;
        r_work <= '0;
        r_cnt  <= '0;
        r_ovf  <= 1'b0;
        o_busy <= 1'b1;
      end else if (o_busy) begin
        r_mag  <= r_mag << 1;
        r_work <= w_shifted;
        r_cnt  <= r_cnt + CNT_W'(1);
        r_ovf  <= r_ovf | w_carry;
        o_busy <= !w_last;
      end
      // The top digit is reserved for the minus sign on negative values.
      if (w_last) begin
        o_bcd      <= w_shifted;
        o_overflow <= r_ovf | w_carry | (i_neg & w_top_nz);
      end
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Seven-segment display controller: binary-to-BCD conversion, sign/overflow/
// leading-zero rendering and time-multiplexed active-low digit scan.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGITS  = 4,
  parameter int REFRESH = 4,
  parameter bit SIGNED  = 1'b0,
  parameter bit LZB     = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [WIDTH-1:0]    i_value,
  input  logic                i_load,
  output logic                o_busy,
  output logic [4*DIGITS-1:0] o_bcd,
  output logic                o_overflow,
  output logic [6:0]          o_seg,
  output logic [DIGITS-1:0]   o_an
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SLOT_W = $clog2(REFRESH);

  logic              w_neg;
  logic [WIDTH-1:0]  w_mag;
  logic              w_done;
  logic              w_accept;
  logic              r_sign_cap;
  logic              r_sign;
  logic [SLOT_W-1:0] r_slot;
  logic [IDX_W-1:0]  r_idx;
  logic [DIGITS-1:0] w_zero_from;
  bcd_digit_t        w_digit;
  logic              w_zero_sel;
  logic [6:0]        w_pat;
  logic [DIGITS-1:0] w_an_lit;

  assign w_neg    = SIGNED && i_value[WIDTH-1];
  assign w_mag    = w_neg ? (~i_value + WIDTH'(1)) : i_value;
  assign w_accept = i_load && (!o_busy || w_done);

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (i_load),
    .i_mag      (w_mag),
    .i_neg      (r_sign_cap),
    .o_busy     (o_busy),
    .o_bcd      (o_bcd),
    .o_overflow (o_overflow),
    .o_done     (w_done)
  );

  // Sign is captured with the value but only shown once the result is published.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sign_cap <= 1'b0;
      r_sign     <= 1'b0;
    end else begin
      if (w_accept) r_sign_cap <= w_neg;
      if (w_done)   r_sign     <= r_sign_cap;
    end
  end

  // Segment pattern for the digit currently being scanned.
  always_comb begin
    w_zero_from[DIGITS-1] = (o_bcd[4*DIGITS-1 -: 4] == 4'd0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      w_zero_from[k] = w_zero_from[k+1] && (o_bcd[4*k +: 4] == 4'd0);
    end
    w_digit    = 4'd0;
    w_zero_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      w_digit    = (IDX_W'(k) == r_idx) ? o_bcd[4*k +: 4] : w_digit;
      w_zero_sel = (IDX_W'(k) == r_idx) ? w_zero_from[k]  : w_zero_sel;
    end
    if (o_overflow) begin
      w_pat = SEG_E;
    end else if (r_sign && (r_idx == IDX_W'(DIGITS - 1))) begin
      w_pat = SEG_MINUS;
    end else if (LZB && (r_idx != IDX_W'(0)) && w_zero_sel) begin
      w_pat = SEG_BLANK;
    end else begin
      w_pat = digit_to_seg(w_digit);
    end
    w_an_lit = ~(DIGITS'(1) << r_idx);
  end

  // Scan counters: slot 0 is dead time where the next digit's pattern is loaded.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_slot <= '0;
      r_idx  <= '0;
      o_an   <= '1;
      o_seg  <= SEG_BLANK;
    end else begin
      if (r_slot == SLOT_W'(REFRESH - 1)) begin
        r_slot <= '0;
        o_an   <= '1;
        r_idx  <= (r_idx == IDX_W'(DIGITS - 1)) ? IDX_W'(0) : (r_idx + IDX_W'(1));
      end else begin
        r_slot <= r_slot + SLOT_W'(1);
        o_an   <= w_an_lit;
      end
      if (r_slot == SLOT_W'(0)) o_seg <= w_pat;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed, table-driven bench: three controller instances (8-bit unsigned,
// 8-bit signed, 16-bit signed) checked against hand-computed BCD and segments.
module tb_seg_display_ctrl;

  localparam logic [6:0] S_BL = 7'h7F, S_MI = 7'h3F, S_E = 7'h06;
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S5 = 7'h12;
  localparam logic [6:0] S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  v_u8, v_s8;
  logic [15:0] v_s16;
  logic        l_u8, l_s8, l_s16;
  logic        busy_u8, busy_s8, busy_s16;
  logic [15:0] bcd_u8, bcd_s8, bcd_s16;
  logic        ovf_u8, ovf_s8, ovf_s16;
  logic [6:0]  seg_u8, seg_s8, seg_s16;
  logic [3:0]  an_u8, an_s8, an_s16;

  seg_display_ctrl #(.WIDTH(8), .DIGITS(4), .REFRESH(4), .SIGNED(1'b0), .LZB(1'b1)) u_u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(v_u8), .i_load(l_u8), .o_busy(busy_u8),
    .o_bcd(bcd_u8), .o_overflow(ovf_u8), .o_seg(seg_u8), .o_an(an_u8));
  seg_display_ctrl #(.WIDTH(8), .DIGITS(4), .REFRESH(4), .SIGNED(1'b1), .LZB(1'b1)) u_s8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(v_s8), .i_load(l_s8), .o_busy(busy_s8),
    .o_bcd(bcd_s8), .o_overflow(ovf_s8), .o_seg(seg_s8), .o_an(an_s8));
  seg_display_ctrl #(.WIDTH(16), .DIGITS(4), .REFRESH(4), .SIGNED(1'b1), .LZB(1'b1)) u_s16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(v_s16), .i_load(l_s16), .o_busy(busy_s16),
    .o_bcd(bcd_s16), .o_overflow(ovf_s16), .o_seg(seg_s16), .o_an(an_s16));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int              sel;
    logic [15:0]     value;
    logic [15:0]     bcd;
    logic            ovf;
    logic [3:0][6:0] segs;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic get_out(input int sel, output logic busy, output logic [15:0] bcd,
                         output logic ovf, output logic [6:0] seg, output logic [3:0] an);
    case (sel)
      0:       begin busy = busy_u8;  bcd = bcd_u8;  ovf = ovf_u8;  seg = seg_u8;  an = an_u8;  end
      1:       begin busy = busy_s8;  bcd = bcd_s8;  ovf = ovf_s8;  seg = seg_s8;  an = an_s8;  end
      default: begin busy = busy_s16; bcd = bcd_s16; ovf = ovf_s16; seg = seg_s16; an = an_s16; end
    endcase
  endtask

  task automatic do_load(input int sel, input logic [15:0] value);
    case (sel)
      0:       begin v_u8  = value[7:0]; l_u8  = 1'b1; end
      1:       begin v_s8  = value[7:0]; l_s8  = 1'b1; end
      default: begin v_s16 = value;      l_s16 = 1'b1; end
    endcase
    tick();
    l_u8 = 1'b0; l_s8 = 1'b0; l_s16 = 1'b0;
  endtask

  task automatic wait_idle(input int sel, inout int n);
    logic b, o; logic [15:0] d; logic [6:0] s; logic [3:0] a;
    get_out(sel, b, d, o, s, a);
    while (b && n < 64) begin
      tick();
      n++;
      get_out(sel, b, d, o, s, a);
    end
  endtask

  task automatic capture(input int sel, output logic [3:0][6:0] got);
    logic b, o; logic [15:0] d; logic [6:0] s; logic [3:0] a;
    got = 'x;
    repeat (16) tick();
    for (int i = 0; i < 32; i++) begin
      get_out(sel, b, d, o, s, a);
      if ($countones(~a) == 1) begin
        for (int k = 0; k < 4; k++) if (!a[k]) got[k] = s;
      end
      tick();
    end
  endtask

  task automatic chk_digits(input string name, input logic [3:0][6:0] got,
                            input logic [3:0][6:0] exp);
    for (int k = 0; k < 4; k++) chk($sformatf("%s_dig%0d", name, k), {25'd0, got[k]}, {25'd0, exp[k]});
  endtask

  initial begin
    logic [3:0]      an_exp [8];
    logic [3:0][6:0] got;
    logic b, o; logic [15:0] d; logic [6:0] s; logic [3:0] a;
    int n;

    vecs[0]  = '{0, 16'd255,   16'h0255, 1'b0, {S_BL, S2,   S5,   S5}};
    vecs[1]  = '{0, 16'd0,     16'h0000, 1'b0, {S_BL, S_BL, S_BL, S0}};
    vecs[2]  = '{0, 16'd100,   16'h0100, 1'b0, {S_BL, S1,   S0,   S0}};
    vecs[3]  = '{1, 16'h00F6,  16'h0010, 1'b0, {S_MI, S_BL, S1,   S0}};
    vecs[4]  = '{1, 16'd127,   16'h0127, 1'b0, {S_BL, S1,   S2,   S7}};
    vecs[5]  = '{1, 16'h0080,  16'h0128, 1'b0, {S_MI, S1,   S2,   S8}};
    vecs[6]  = '{2, 16'd9999,  16'h9999, 1'b0, {S9,   S9,   S9,   S9}};
    vecs[7]  = '{2, 16'd10000, 16'h0000, 1'b1, {S_E,  S_E,  S_E,  S_E}};
    vecs[8]  = '{2, 16'hFC18,  16'h1000, 1'b1, {S_E,  S_E,  S_E,  S_E}};
    vecs[9]  = '{2, 16'hFFFF,  16'h0001, 1'b0, {S_MI, S_BL, S_BL, S1}};
    vecs[10] = '{2, 16'h8000,  16'h2768, 1'b1, {S_E,  S_E,  S_E,  S_E}};
    an_exp = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101};

    rst_n = 1'b0;
    v_u8 = 8'd0; v_s8 = 8'd0; v_s16 = 16'd0;
    l_u8 = 1'b0; l_s8 = 1'b0; l_s16 = 1'b0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy_u8}, 32'd0);
    chk("rst_bcd",  {16'd0, bcd_u8}, 32'd0);
    chk("rst_ovf",  {31'd0, ovf_u8}, 32'd0);
    chk("rst_seg",  {25'd0, seg_u8}, {25'd0, S_BL});
    chk("rst_an",   {28'd0, an_u8}, 32'hF);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("scan_an%0d", i), {28'd0, an_u8}, {28'd0, an_exp[i]});
      tick();
    end
    capture(0, got);
    chk_digits("rst_disp", got, {S_BL, S_BL, S_BL, S0});

    for (int v = 0; v < 11; v++) begin
      do_load(vecs[v].sel, vecs[v].value);
      n = 0;
      wait_idle(vecs[v].sel, n);
      get_out(vecs[v].sel, b, d, o, s, a);
      chk($sformatf("v%0d_cycles", v), n, (vecs[v].sel == 2) ? 32'd16 : 32'd8);
      chk($sformatf("v%0d_bcd", v), {16'd0, d}, {16'd0, vecs[v].bcd});
      chk($sformatf("v%0d_ovf", v), {31'd0, o}, {31'd0, vecs[v].ovf});
      capture(vecs[v].sel, got);
      chk_digits($sformatf("v%0d", v), got, vecs[v].segs);
    end

    // A second load during a conversion must be dropped.
    do_load(0, 16'd255);
    tick();
    tick();
    do_load(0, 16'd7);
    n = 3;
    wait_idle(0, n);
    chk("ign_cycles", n, 32'd8);
    chk("ign_bcd", {16'd0, bcd_u8}, 32'h0255);
    chk("ign_ovf", {31'd0, ovf_u8}, 32'd0);

    // Reset part-way through a conversion aborts it and the display reverts to 0.
    do_load(0, 16'd255);
    repeat (3) tick();
    chk("abort_busy_before", {31'd0, busy_u8}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("abort_busy", {31'd0, busy_u8}, 32'd0);
    chk("abort_bcd",  {16'd0, bcd_u8}, 32'd0);
    chk("abort_ovf",  {31'd0, ovf_u8}, 32'd0);
    rst_n = 1'b1;
    capture(0, got);
    chk_digits("abort_disp", got, {S_BL, S_BL, S_BL, S0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
